clk_div_bank: RTL and testbench

//  Parametrised multi-channel successor to the single-channel Counter clock divider.

---
 rtl/clk_div_bank.sv | 126 ++++++++++++
 tb/tb_clk_div_bank.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of CHANNELS independent clock dividers / strobe generators.
//
// Each channel counts 0..L-1 and wraps, where L is a shadow copy of its
// limit input. The shadow is only refreshed at a wrap (or while idle, or on
// load), so a new limit never produces a runt period.
//
// Parameters
//   CHANNELS  number of divider channels (>=1)
//   WIDTH     width of each limit / count register (>=2)
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   en[i]         channel count enable
//   mode[i]       0 = toggle (50% clock, period 2L), 1 = pulse (1-cycle strobe, period L)
//   load[i]       synchronous restart of channel i (1-cycle pulse)
//   sync_restart  (only with CLK_DIV_SYNC_RESTART_EN) restart all channels at once
//   limit         channel i period in limit[i*WIDTH +: WIDTH]; 0 parks the channel idle
//   clkout[i]     divided clock or strobe, registered
//   tick[i]       1-cycle wrap strobe, registered, independent of mode
//
// Optional feature macro: CLK_DIV_SYNC_RESTART_EN adds the sync_restart input.

module clk_div_ch #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] limit,
  output logic             clkout,
  output logic             tick
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             clkout_q, clkout_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    clkout_d = clkout_q;
    tick_d   = 1'b0;
    if (load) begin
      cnt_d    = '0;
      shadow_d = limit;
      clkout_d = 1'b0;
    end else if (shadow_q == '0) begin
      // idle: keep re-sampling limit so a nonzero value arms the channel
      cnt_d    = '0;
      shadow_d = limit;
      clkout_d = 1'b0;
    end else if (!en) begin
      if (mode) clkout_d = 1'b0;
    end else if (cnt_q == shadow_q - WIDTH'(1)) begin
      cnt_d    = '0;
      tick_d   = 1'b1;
      shadow_d = limit;
      clkout_d = mode ? 1'b1 : ~clkout_q;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
      if (mode) clkout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      clkout_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      clkout_q <= clkout_d;
      tick_q   <= tick_d;
    end
  end

  assign clkout = clkout_q;
  assign tick   = tick_q;

endmodule

module clk_div_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS-1:0]       load,
`ifdef CLK_DIV_SYNC_RESTART_EN
  input  logic                      sync_restart,
`endif
  input  logic [CHANNELS*WIDTH-1:0] limit,
  output logic [CHANNELS-1:0]       clkout,
  output logic [CHANNELS-1:0]       tick
);

  logic [CHANNELS-1:0] load_eff;

`ifdef CLK_DIV_SYNC_RESTART_EN
  // a shared restart lands on every channel in the same cycle -> phase aligned
  assign load_eff = load | {CHANNELS{sync_restart}};
`else
  assign load_eff = load;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clk_div_ch #(.WIDTH(WIDTH)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en[g]),
      .mode   (mode[g]),
      .load   (load_eff[g]),
      .limit  (limit[g*WIDTH +: WIDTH]),
      .clkout (clkout[g]),
      .tick   (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
module tb_clk_div_bank;
  localparam int CH = 2;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   en, mode, load;
  logic            sync_restart;
  logic [CH*W-1:0] limit;
  logic [CH-1:0]   clkout, tick;

  always #5 clk = ~clk;

  clk_div_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode         (mode),
    .load         (load),
`ifdef CLK_DIV_SYNC_RESTART_EN
    .sync_restart (sync_restart),
`endif
    .limit        (limit),
    .clkout       (clkout),
    .tick         (tick)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference state, one entry per channel
  logic [W-1:0]  m_cnt [CH];
  logic [W-1:0]  m_sh  [CH];
  logic [CH-1:0] m_clk, m_tick;
  logic [2*CH-1:0] sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic [CH-1:0] nclk, ntick;
    logic [CH-1:0] ld;
    logic [W-1:0]  lim;
    ld = load;
`ifdef CLK_DIV_SYNC_RESTART_EN
    if (sync_restart) ld = '1;
`endif
    for (int c = 0; c < CH; c++) begin
      lim = limit[c*W +: W];
      nclk[c]  = m_clk[c];
      ntick[c] = 1'b0;
      if (ld[c]) begin
        m_cnt[c] = '0; m_sh[c] = lim; nclk[c] = 1'b0;
      end else if (m_sh[c] == 0) begin
        m_cnt[c] = '0; m_sh[c] = lim; nclk[c] = 1'b0;
      end else if (!en[c]) begin
        if (mode[c]) nclk[c] = 1'b0;
      end else if (int'(m_cnt[c]) + 1 == int'(m_sh[c])) begin
        m_cnt[c] = '0; m_sh[c] = lim; ntick[c] = 1'b1;
        nclk[c] = mode[c] ? 1'b1 : ~m_clk[c];
      end else begin
        m_cnt[c] = m_cnt[c] + 1'b1;
        if (mode[c]) nclk[c] = 1'b0;
      end
    end
    m_clk  = nclk;
    m_tick = ntick;
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = '0; m_sh[c] = '0;
    end
    m_clk = '0; m_tick = '0;
    sb.delete();
  endtask

  // one clock: predict, push, edge, pop and compare every output bit
  task automatic cycle();
    logic [2*CH-1:0] e;
    model_step();
    sb.push_back({m_clk, m_tick});
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    checks++;
    if ({clkout, tick} !== e) begin
      errors++;
      $display("FAIL scoreboard clkout,tick act=%b exp=%b (cycle %0d)", {clkout, tick}, e, cyc);
    end
  endtask

  task automatic run_until_tick(input int ch, input int budget, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (tick[ch] !== 1'b1 && n < budget);
    if (tick[ch] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL tick_timeout ch%0d act=none exp=tick within %0d", ch, budget);
    end
  endtask

  typedef struct {
    logic [CH-1:0] en;
    logic [CH-1:0] mode;
    logic [W-1:0]  lim0;
    logic [W-1:0]  lim1;
    int            n;
    int            t0, t1;  // expected tick counts
    int            h0, h1;  // expected clkout-high cycle counts
  } vec_t;

  vec_t vecs[5];

  initial begin
    int t0, t1, h0, h1, n;
    vecs[0] = '{en:2'b11, mode:2'b00, lim0:8'd10, lim1:8'd13, n:40, t0:4,  t1:3,  h0:20, h1:15};
    vecs[1] = '{en:2'b11, mode:2'b11, lim0:8'd3,  lim1:8'd1,  n:12, t0:4,  t1:12, h0:4,  h1:12};
    vecs[2] = '{en:2'b11, mode:2'b00, lim0:8'd1,  lim1:8'd2,  n:10, t0:10, t1:5,  h0:5,  h1:5};
    vecs[3] = '{en:2'b01, mode:2'b10, lim0:8'd4,  lim1:8'd7,  n:9,  t0:2,  t1:0,  h0:4,  h1:0};
    vecs[4] = '{en:2'b11, mode:2'b00, lim0:8'd0,  lim1:8'd5,  n:10, t0:0,  t1:2,  h0:0,  h1:5};

    rst = 1'b0; en = '0; mode = '0; load = '0; sync_restart = 1'b0; limit = '0;
    model_reset();
    #3;
    chk("reset_clkout", int'(clkout), 0);
    chk("reset_tick", int'(tick), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // table of restarted segments
    for (int i = 0; i < 5; i++) begin
      en = vecs[i].en; mode = vecs[i].mode;
      limit = {vecs[i].lim1, vecs[i].lim0};
      load = '1; cycle(); load = '0;
      t0 = 0; t1 = 0; h0 = 0; h1 = 0;
      repeat (vecs[i].n) begin
        cycle();
        t0 += int'(tick[0]); t1 += int'(tick[1]);
        h0 += int'(clkout[0]); h1 += int'(clkout[1]);
      end
      chk($sformatf("v%0d_ticks0", i), t0, vecs[i].t0);
      chk($sformatf("v%0d_ticks1", i), t1, vecs[i].t1);
      chk($sformatf("v%0d_high0", i), h0, vecs[i].h0);
      chk($sformatf("v%0d_high1", i), h1, vecs[i].h1);
    end

    // async reset mid-run with L=1 so tick is high going in
    limit = {8'd1, 8'd1}; en = '1; mode = '0;
    load = '1; cycle(); load = '0; cycle();
    chk("pre_rst_tick", int'(tick), 3);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_clkout", int'(clkout), 0);
    chk("async_rst_tick", int'(tick), 0);
    model_reset();
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // shadowed limit: 10 -> 13 at cnt=4
    en = 2'b01; mode = 2'b00; limit = {8'd0, 8'd10};
    load = 2'b01; cycle(); load = '0;
    repeat (4) cycle();
    limit = {8'd0, 8'd13};
    run_until_tick(0, 40, n); chk("shadow_cur_period", n, 6);
    run_until_tick(0, 40, n); chk("shadow_next_period", n, 13);

    // pulse mode, then limit 0 -> idle after the wrap
    mode = 2'b01; limit = {8'd0, 8'd3};
    load = 2'b01; cycle(); load = '0;
    h0 = 0;
    repeat (6) begin cycle(); h0 += int'(clkout[0]); end
    chk("pulse_highs", h0, 2);
    cycle();
    limit = '0;
    run_until_tick(0, 10, n); chk("last_pulse", n, 2);
    chk("last_pulse_clkout", int'(clkout[0]), 1);
    h0 = 0;
    repeat (6) begin cycle(); h0 += int'(clkout[0]) + int'(tick[0]); end
    chk("idle_quiet", h0, 0);

    // pause at cnt=6 for 5 cycles
    mode = 2'b00; limit = {8'd0, 8'd10}; en = 2'b01;
    load = 2'b01; cycle(); load = '0;
    repeat (6) cycle();
    en = 2'b00; t0 = 0;
    repeat (5) begin cycle(); t0 += int'(tick[0]); end
    chk("pause_no_tick", t0, 0);
    en = 2'b01;
    run_until_tick(0, 20, n); chk("pause_resume", n, 4);

    // load on the wrap cycle beats the wrap
    limit = {8'd0, 8'd3};
    load = 2'b01; cycle(); load = '0;
    repeat (2) cycle();
    load = 2'b01; cycle(); load = '0;
    chk("load_wrap_tick", int'(tick[0]), 0);
    chk("load_wrap_clkout", int'(clkout[0]), 0);
    run_until_tick(0, 10, n); chk("load_wrap_next", n, 3);

`ifdef CLK_DIV_SYNC_RESTART_EN
    // different phases, then a shared restart aligns them
    en = 2'b11; mode = 2'b11; limit = {8'd8, 8'd4};
    load = 2'b01; cycle(); load = '0;
    repeat (3) cycle();
    load = 2'b10; cycle(); load = '0;
    repeat (2) cycle();
    sync_restart = 1'b1; cycle(); sync_restart = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      cycle();
      chk($sformatf("sync_ch0_k%0d", k), int'(tick[0]), (k % 4 == 0) ? 1 : 0);
      chk($sformatf("sync_ch1_k%0d", k), int'(tick[1]), (k % 8 == 0) ? 1 : 0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end
endmodule
